// File: rtl/axi_switch_0_ref_example_example_pkt_arbiter_if.sv
// Bundle of the per-channel source handshake and the downstream FIFO handshake
// for the packet arbiter; "slave" is the arbiter's view, "master" the environment's.
interface axi_switch_0_ref_example_example_pkt_arbiter_if #(
    parameter int C_NUM_SI     = 4,
    parameter int C_MESG_WIDTH = 8
);
    logic [C_NUM_SI*C_MESG_WIDTH-1:0] s_mesg;
    logic [C_NUM_SI-1:0]              s_last;
    logic [C_NUM_SI-1:0]              s_valid;
    logic [C_NUM_SI-1:0]              s_ready;
    logic [C_MESG_WIDTH-1:0]          m_mesg;
    logic                             m_last;
    logic                             m_valid;
    logic                             m_ready;
    logic                             m_afull;
    logic [C_NUM_SI-1:0]              m_grant;
    logic                             m_busy;

    modport slave (
        input  s_mesg, s_last, s_valid, m_ready, m_afull,
        output s_ready, m_mesg, m_last, m_valid, m_grant, m_busy
    );

    modport master (
        output s_mesg, s_last, s_valid, m_ready, m_afull,
        input  s_ready, m_mesg, m_last, m_valid, m_grant, m_busy
    );
endinterface

// File: rtl/axi_switch_0_ref_example_example_pkt_arbiter.sv
// Round-robin packet arbiter: locks one source channel until its last beat and passes it
// straight through to the downstream FIFO. Define PKT_ARBITER_AFULL_GATE_EN to hold off new grants on m_afull.
module axi_switch_0_ref_example_example_pkt_arbiter #(
    parameter int C_NUM_SI     = 4,
    parameter int C_MESG_WIDTH = 8
) (
    input  logic aclk,
    input  logic areset,
    input  logic aclken,
    axi_switch_0_ref_example_example_pkt_arbiter_if.slave bus
);

    localparam int IDX_W = (C_NUM_SI > 1) ? $clog2(C_NUM_SI) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [C_NUM_SI-1:0] grant_r;
    logic [C_NUM_SI-1:0] grant_nxt_s;
    logic [IDX_W-1:0]    cur_idx_r;
    logic [IDX_W-1:0]    cur_idx_nxt_s;
    logic [IDX_W-1:0]    last_grant_r;
    logic [IDX_W-1:0]    last_grant_nxt_s;
    logic [IDX_W-1:0]    sel_idx_s;
    logic [IDX_W-1:0]    cand_idx_s;
    logic                sel_found_s;
    logic                gate_s;
    logic                hs_last_s;

`ifdef PKT_ARBITER_AFULL_GATE_EN
    assign gate_s = bus.m_afull;
`else
    assign gate_s = 1'b0;
`endif

    // Round-robin search: first requester starting just after the last granted channel
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        cand_idx_s  = '0;
        for (int k = 1; k <= C_NUM_SI; k++) begin
            cand_idx_s = IDX_W'((int'(last_grant_r) + k) % C_NUM_SI);
            if (!sel_found_s && bus.s_valid[cand_idx_s]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = cand_idx_s;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Combinational pass-through of the locked channel; everything quiet while idle
    always_comb begin
        bus.m_mesg  = '0;
        bus.m_last  = 1'b0;
        bus.m_valid = 1'b0;
        bus.s_ready = '0;
        if (state_r == LOCKED) begin
            bus.m_mesg  = bus.s_mesg[cur_idx_r*C_MESG_WIDTH +: C_MESG_WIDTH];
            bus.m_last  = bus.s_last[cur_idx_r];
            bus.m_valid = bus.s_valid[cur_idx_r] & aclken;
            bus.s_ready = grant_r & {C_NUM_SI{bus.m_ready & aclken}};
        end else begin
            bus.m_mesg  = '0;
        end
    end

    assign hs_last_s = bus.m_valid & bus.m_ready & bus.m_last;

    // Next-state logic: grant only from IDLE, release only on the last-beat handshake
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        cur_idx_nxt_s    = cur_idx_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (aclken && sel_found_s && !gate_s) begin
                    state_nxt_s   = LOCKED;
                    grant_nxt_s   = {{(C_NUM_SI-1){1'b0}}, 1'b1} << sel_idx_s;
                    cur_idx_nxt_s = sel_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOCKED: begin
                if (hs_last_s) begin
                    state_nxt_s      = IDLE;
                    grant_nxt_s      = '0;
                    last_grant_nxt_s = cur_idx_r;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // State registers; reset leaves channel 0 with first priority
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r      <= IDLE;
            grant_r      <= '0;
            cur_idx_r    <= '0;
            last_grant_r <= IDX_W'(C_NUM_SI - 1);
        end else if (aclken) begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            cur_idx_r    <= cur_idx_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end else begin
            state_r      <= state_r;
        end
    end

    assign bus.m_grant = grant_r;
    assign bus.m_busy  = (state_r == LOCKED);

endmodule
